axi_multi_perf_monitor: RTL and testbench

//  Next-gen AXI read performance monitor: NUM_CH independent AXI read channels observed in parallel.
//  Per channel: data beats, transactions, and AR->last-R latency (sum/min/max) over a runtime-programmable window.

---
 rtl/axi_multi_perf_monitor.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_multi_perf_monitor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_multi_perf_monitor.sv
// ---------------------------------------------------------------------------
// axi_multi_perf_monitor
//   Passive read-performance tap for NUM_CH independent AXI read channels.
//   For each channel it counts R beats and completed transactions and
//   measures AR-to-last-R latency (sum/min/max) over a programmable window.
//   All results are read back through one registered, muxed 32-bit port.
//
//   Optional feature macro: AXI_PERF_HIST_EN adds a per-channel 8-bin latency
//   histogram (fields 8-15). Without it, those fields read 0.
//
// Ports
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_start/i_stop/i_clear   measurement control (clear > start > stop/expiry)
//   i_window_cycles          window length in cycles, 0 = unlimited
//   i_arvalid..i_rlast       per-channel AR/R handshake taps
//   i_rd_sel, i_rd_field     readout channel and field select
//   o_rd_data                selected field, one cycle after the select
//   o_running                high while measuring
//   o_window_done            high in the final cycle of an expiring window
//   o_overflow               sticky per channel: AR seen with timestamp FIFO full
// ---------------------------------------------------------------------------
module axi_multi_perf_monitor #(
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 32,
  parameter int TS_W            = 16,
  parameter int MAX_OUTSTANDING = 16,
  parameter int WINDOW_W        = 24,
  parameter int CLOCK_FREQ      = 500,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset_n,
  input  logic                                        i_start,
  input  logic                                        i_stop,
  input  logic                                        i_clear,
  input  logic [WINDOW_W-1:0]                         i_window_cycles,
  input  logic [NUM_CH-1:0]                           i_arvalid,
  input  logic [NUM_CH-1:0]                           i_arready,
  input  logic [NUM_CH-1:0]                           i_rvalid,
  input  logic [NUM_CH-1:0]                           i_rready,
  input  logic [NUM_CH-1:0]                           i_rlast,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_rd_sel,
  input  logic [3:0]                                  i_rd_field,
  output logic [31:0]                                 o_rd_data,
  output logic                                        o_running,
  output logic                                        o_window_done,
  output logic [NUM_CH-1:0]                           o_overflow
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);   // MAX_OUTSTANDING >= 2
  localparam int OCC_W = PTR_W + 1;
  localparam int CMP_W = (CNT_W > WINDOW_W) ? CNT_W : WINDOW_W;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;

  state_t              state;
  logic [TS_W-1:0]     ts;
  logic [CNT_W-1:0]    elapsed;

  logic [PTR_W-1:0]    wr_ptr   [NUM_CH];
  logic [PTR_W-1:0]    rd_ptr   [NUM_CH];
  logic [OCC_W-1:0]    occ      [NUM_CH];
  logic [TS_W-1:0]     fifo_mem [NUM_CH][MAX_OUTSTANDING];

  logic [CNT_W-1:0]    beats    [NUM_CH];
  logic [CNT_W-1:0]    txns     [NUM_CH];
  logic [CNT_W-1:0]    lat_sum  [NUM_CH];
  logic [TS_W-1:0]     lat_min  [NUM_CH];
  logic [TS_W-1:0]     lat_max  [NUM_CH];

  logic [NUM_CH-1:0]   push, pop, beat, ovf_set;
  logic [TS_W-1:0]     lat      [NUM_CH];
  logic                run_act, restart, win_hit;
  logic [31:0]         rd_mux;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [TS_W-1:0]  b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Restart covers both clear (-> IDLE) and start from outside RUN (-> RUN);
  // either way statistics, FIFOs, timestamp and overflow start from zero.
  assign restart = i_clear || (i_start && (state != ST_RUN));
  assign run_act = (state == ST_RUN) && !i_clear;

  // Compare elapsed+1 against the window in a widened domain so neither
  // operand truncates and saturated elapsed cannot wrap into a false hit.
  assign win_hit = (i_window_cycles != '0) &&
                   ((CMP_W+1)'(elapsed) + (CMP_W+1)'(1) == (CMP_W+1)'(i_window_cycles));

  // The pulse marks the last RUN cycle itself, so it precedes o_running
  // falling by exactly one cycle.
  assign o_window_done = run_act && win_hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    push    = '0;
    pop     = '0;
    beat    = '0;
    ovf_set = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      lat[c]     = ts - fifo_mem[c][rd_ptr[c]];   // modular, aliases past 2^TS_W
      push[c]    = run_act && i_arvalid[c] && i_arready[c] && (occ[c] != OCC_W'(MAX_OUTSTANDING));
      ovf_set[c] = run_act && i_arvalid[c] && i_arready[c] && (occ[c] == OCC_W'(MAX_OUTSTANDING));
      beat[c]    = run_act && i_rvalid[c] && i_rready[c];
      pop[c]     = beat[c] && i_rlast[c] && (occ[c] != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      o_running  <= 1'b0;
      ts         <= '0;
      elapsed    <= '0;
      o_overflow <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]  <= '0;
        rd_ptr[c]  <= '0;
        occ[c]     <= '0;
        beats[c]   <= '0;
        txns[c]    <= '0;
        lat_sum[c] <= '0;
        lat_min[c] <= '1;
        lat_max[c] <= '0;
      end
    end else if (restart) begin
      state      <= i_clear ? ST_IDLE : ST_RUN;
      o_running  <= !i_clear;
      ts         <= '0;
      elapsed    <= '0;
      o_overflow <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]  <= '0;
        rd_ptr[c]  <= '0;
        occ[c]     <= '0;
        beats[c]   <= '0;
        txns[c]    <= '0;
        lat_sum[c] <= '0;
        lat_min[c] <= '1;
        lat_max[c] <= '0;
      end
    end else if (state == ST_RUN) begin
      ts      <= ts + TS_W'(1);
      elapsed <= sat_inc(elapsed);
      if (i_stop || win_hit) begin
        state     <= ST_HOLD;
        o_running <= 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        occ[c] <= occ[c] + OCC_W'(push[c]) - OCC_W'(pop[c]);
        if (ovf_set[c]) o_overflow[c] <= 1'b1;
        if (beat[c])    beats[c]      <= sat_inc(beats[c]);
        if (pop[c]) begin
          txns[c]    <= sat_inc(txns[c]);
          lat_sum[c] <= sat_add(lat_sum[c], lat[c]);
          if (lat[c] < lat_min[c]) lat_min[c] <= lat[c];
          if (lat[c] > lat_max[c]) lat_max[c] <= lat[c];
        end
      end
    end
  end

  // NOTE: timestamp storage has no reset; pointers and occupancy alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (push[c]) fifo_mem[c][wr_ptr[c]] <= ts;
  end

`ifdef AXI_PERF_HIST_EN
  logic [15:0] hist [NUM_CH][8];

  function automatic logic [2:0] hist_bin(input logic [TS_W-1:0] l);
    logic [31:0] lz;
    lz = 32'(l);
    if      (lz < 32'd8)   return 3'd0;
    else if (lz < 32'd16)  return 3'd1;
    else if (lz < 32'd32)  return 3'd2;
    else if (lz < 32'd64)  return 3'd3;
    else if (lz < 32'd128) return 3'd4;
    else if (lz < 32'd256) return 3'd5;
    else if (lz < 32'd512) return 3'd6;
    else                   return 3'd7;
  endfunction

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n || restart) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int b = 0; b < 8; b++) hist[c][b] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (pop[c] && !(&hist[c][hist_bin(lat[c])]))
          hist[c][hist_bin(lat[c])] <= hist[c][hist_bin(lat[c])] + 16'd1;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_rd_sel == SEL_W'(c)) begin
        case (i_rd_field)
          4'd0:    rd_mux = 32'(beats[c]);
          4'd1:    rd_mux = 32'(txns[c]);
          4'd2:    rd_mux = 32'(lat_sum[c]);
          4'd3:    rd_mux = 32'(lat_min[c]);
          4'd4:    rd_mux = 32'(lat_max[c]);
          4'd5:    rd_mux = 32'(elapsed);
          4'd6:    rd_mux = {16'(occ[c]), 15'b0, o_overflow[c]};
          4'd7:    rd_mux = {4'h1, 12'(CLOCK_FREQ), 16'(DATA_WIDTH)};
`ifdef AXI_PERF_HIST_EN
          default: rd_mux = 32'(hist[c][i_rd_field[2:0]]);
`else
          default: rd_mux = '0;
`endif
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_rd_data <= '0;
    else            o_rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_axi_multi_perf_monitor.sv
// ---------------------------------------------------------------------------
// tb_axi_multi_perf_monitor
//   Directed vectors with hand-computed expectations for the read monitor:
//   single-transaction latency, FIFO overflow and drain, window expiry,
//   clear/start priority, asynchronous reset mid-burst, FIFO flush on restart,
//   same-cycle push/pop and the optional latency histogram.
// ---------------------------------------------------------------------------
module tb_axi_multi_perf_monitor;

  localparam int NUM_CH = 4;

  logic              clk;
  logic              rst_n;
  logic              i_start, i_stop, i_clear;
  logic [23:0]       i_window_cycles;
  logic [NUM_CH-1:0] i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
  logic [1:0]        i_rd_sel;
  logic [3:0]        i_rd_field;
  logic [31:0]       o_rd_data;
  logic              o_running, o_window_done;
  logic [NUM_CH-1:0] o_overflow;

  int n_vec = 0;
  int n_err = 0;

  axi_multi_perf_monitor dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_start         (i_start),
    .i_stop          (i_stop),
    .i_clear         (i_clear),
    .i_window_cycles (i_window_cycles),
    .i_arvalid       (i_arvalid),
    .i_arready       (i_arready),
    .i_rvalid        (i_rvalid),
    .i_rready        (i_rready),
    .i_rlast         (i_rlast),
    .i_rd_sel        (i_rd_sel),
    .i_rd_field      (i_rd_field),
    .o_rd_data       (o_rd_data),
    .o_running       (o_running),
    .o_window_done   (o_window_done),
    .o_overflow      (o_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs set afterwards apply to the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic stop_run();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
  endtask

  // One cycle of handshakes on a single channel (ready tied with valid).
  task automatic drive(input int ch, input logic ar, input logic rv, input logic rl);
    i_arvalid[ch] = ar;
    i_arready[ch] = ar;
    i_rvalid[ch]  = rv;
    i_rready[ch]  = rv;
    i_rlast[ch]   = rl;
    tick();
    i_arvalid = '0;
    i_arready = '0;
    i_rvalid  = '0;
    i_rready  = '0;
    i_rlast   = '0;
  endtask

  task automatic expect_field(input string tag, input int sel, input int field,
                              input logic [31:0] exp);
    i_rd_sel   = sel[1:0];
    i_rd_field = field[3:0];
    tick();
    check(tag, o_rd_data, exp);
  endtask

  initial begin
    int wd_cycle;
    rst_n           = 1'b0;
    i_start         = 1'b0;
    i_stop          = 1'b0;
    i_clear         = 1'b0;
    i_window_cycles = '0;
    i_arvalid       = '0;
    i_arready       = '0;
    i_rvalid        = '0;
    i_rready        = '0;
    i_rlast         = '0;
    i_rd_sel        = '0;
    i_rd_field      = '0;

    // Reset state
    idle(3);
    check("rst_running",  32'(o_running), 32'd0);
    check("rst_wdone",    32'(o_window_done), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_rd_data",  o_rd_data, 32'd0);
    rst_n = 1'b1;
    tick();
    expect_field("rst_min_ones", 0, 3, 32'h0000_FFFF);
    expect_field("rst_cfg_f7",   0, 7, 32'h11F4_0020);
    expect_field("rst_beats",    0, 0, 32'd0);

    // Single AR at RUN cycle 10, 4 beats with rlast at cycle 30, stop at 31
    start_run();
    check("t1_running", 32'(o_running), 32'd1);
    idle(10);
    drive(0, 1, 0, 0);
    idle(16);
    repeat (3) drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    stop_run();
    check("t1_stopped", 32'(o_running), 32'd0);
    expect_field("t1_beats",   0, 0, 32'd4);
    expect_field("t1_txns",    0, 1, 32'd1);
    expect_field("t1_sum",     0, 2, 32'd20);
    expect_field("t1_min",     0, 3, 32'd20);
    expect_field("t1_max",     0, 4, 32'd20);
    expect_field("t1_elapsed", 0, 5, 32'd32);
    expect_field("t1_f6",      0, 6, 32'd0);
    expect_field("t1_ch1_beats", 1, 0, 32'd0);

    // 17 ARs on ch1: 16 tracked, one overflow; then 16 single-beat responses
    start_run();
    repeat (17) drive(1, 1, 0, 0);
    check("t2_overflow", 32'(o_overflow), 32'h2);
    i_rd_sel   = 2'd1;
    i_rd_field = 4'd6;
    tick();
    check("t2_f6_full", o_rd_data, 32'h0010_0001);
    repeat (16) drive(1, 0, 1, 1);
    stop_run();
    check("t2_ovf_sticky", 32'(o_overflow), 32'h2);
    expect_field("t2_txns",  1, 1, 32'd16);
    expect_field("t2_beats", 1, 0, 32'd16);
    expect_field("t2_sum",   1, 2, 32'd288);
    expect_field("t2_min",   1, 3, 32'd18);
    expect_field("t2_max",   1, 4, 32'd18);
    expect_field("t2_f6_drained", 1, 6, 32'h0000_0001);

    // Window of 100 cycles
    i_window_cycles = 24'd100;
    start_run();
    check("t3_ovf_cleared", 32'(o_overflow), 32'd0);
    wd_cycle = -1;
    for (int n = 0; n < 200; n++) begin
      if (o_window_done) begin
        wd_cycle = n;
        break;
      end
      tick();
    end
    check("t3_done_cycle", 32'(wd_cycle), 32'd99);
    check("t3_run_at_done", 32'(o_running), 32'd1);
    tick();
    check("t3_run_after", 32'(o_running), 32'd0);
    check("t3_pulse_len", 32'(o_window_done), 32'd0);
    expect_field("t3_elapsed", 0, 5, 32'd100);
    i_window_cycles = '0;

    // Clear and start together in HOLD: clear wins
    i_clear = 1'b1;
    i_start = 1'b1;
    tick();
    i_clear = 1'b0;
    i_start = 1'b0;
    check("t4_idle", 32'(o_running), 32'd0);
    expect_field("t4_elapsed", 0, 5, 32'd0);
    expect_field("t4_min",     0, 3, 32'h0000_FFFF);
    drive(0, 0, 1, 1);
    expect_field("t4_idle_ignored", 0, 0, 32'd0);

    // Async reset mid-burst with 3 outstanding
    start_run();
    repeat (3) drive(0, 1, 0, 0);
    repeat (2) drive(0, 0, 1, 0);
    i_rd_sel   = 2'd0;
    i_rd_field = 4'd7;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_running", 32'(o_running), 32'd0);
    check("t5_rst_rd_data", o_rd_data, 32'd0);
    check("t5_rst_overflow", 32'(o_overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_run();
    drive(0, 1, 0, 0);
    idle(4);
    drive(0, 0, 1, 1);
    stop_run();
    expect_field("t5_beats", 0, 0, 32'd1);
    expect_field("t5_txns",  0, 1, 32'd1);
    expect_field("t5_sum",   0, 2, 32'd5);
    expect_field("t5_f6",    0, 6, 32'd0);

    // Restart flushes outstanding ARs: later rlast gives no sample
    start_run();
    repeat (2) drive(3, 1, 0, 0);
    stop_run();
    start_run();
    drive(3, 0, 1, 1);
    stop_run();
    expect_field("t6_beats", 3, 0, 32'd1);
    expect_field("t6_txns",  3, 1, 32'd0);
    expect_field("t6_min",   3, 3, 32'h0000_FFFF);
    expect_field("t6_f6",    3, 6, 32'd0);

    // Push and pop in the same cycle on ch2
    start_run();
    drive(2, 1, 0, 0);
    idle(2);
    drive(2, 1, 1, 1);
    idle(3);
    drive(2, 0, 1, 1);
    stop_run();
    expect_field("t7_txns", 2, 1, 32'd2);
    expect_field("t7_sum",  2, 2, 32'd7);
    expect_field("t7_min",  2, 3, 32'd3);
    expect_field("t7_max",  2, 4, 32'd4);
    expect_field("t7_f6",   2, 6, 32'd0);

    // Latencies 5, 8, 600 on ch2
    start_run();
    drive(2, 1, 0, 0);
    idle(4);
    drive(2, 0, 1, 1);
    idle(4);
    drive(2, 1, 0, 0);
    idle(7);
    drive(2, 0, 1, 1);
    idle(1);
    drive(2, 1, 0, 0);
    idle(599);
    drive(2, 0, 1, 1);
    stop_run();
    expect_field("t8_txns", 2, 1, 32'd3);
    expect_field("t8_sum",  2, 2, 32'd613);
    expect_field("t8_min",  2, 3, 32'd5);
    expect_field("t8_max",  2, 4, 32'd600);
`ifdef AXI_PERF_HIST_EN
    expect_field("t8_bin0", 2, 8,  32'd1);
    expect_field("t8_bin1", 2, 9,  32'd1);
    expect_field("t8_bin2", 2, 10, 32'd0);
    expect_field("t8_bin7", 2, 15, 32'd1);
`else
    expect_field("t8_f8_off",  2, 8,  32'd0);
    expect_field("t8_f15_off", 2, 15, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
